// File: rtl/mhvpis_ctrl.sv
// Four-source vectored interrupt controller feeding a stage-0 sequencer.
// Latches rising edges of irq, selects the highest eligible source and tracks its service.
module mhvpis_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'hF0,
  parameter int         NSRC     = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] irq,
  input  logic [NSRC-1:0] itr_mask,
  input  logic            itr_ack,
  input  logic            itr_done,
  output logic            i_pending,
  output logic [7:0]      vector,
  output logic [1:0]      active_id,
  output logic            in_service,
  output logic [NSRC-1:0] overrun,
  output logic [2:0]      itr_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    PEND    = 3'b010,
    SERVICE = 3'b100
  } state_t;

  state_t          state_reg, state_next;
  logic [NSRC-1:0] irq_q_reg;
  logic [NSRC-1:0] req_lat_reg, req_lat_next;
  logic [NSRC-1:0] overrun_reg, overrun_next;
  logic [7:0]      vector_reg;
  logic [1:0]      active_id_reg;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] ack_clear;
  logic            any_eligible;
  logic [1:0]      winner;

  assign rise         = irq & ~irq_q_reg;
  assign eligible     = req_lat_reg & itr_mask;
  assign any_eligible = |eligible;

  // Highest index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    winner = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i]) winner = 2'(i);
    end
  end

  // A new edge on the same edge as the ack-clear keeps the request and is not an overrun.
  always_comb begin
    ack_clear = '0;
    if (state_reg == PEND && itr_ack) ack_clear[active_id_reg] = 1'b1;
    req_lat_next = (req_lat_reg & ~ack_clear) | rise;
    overrun_next = overrun_reg | (rise & req_lat_reg & ~ack_clear);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_eligible) state_next = PEND;
      PEND: begin
        if (itr_ack)                       state_next = SERVICE;
        else if (!itr_mask[active_id_reg]) state_next = IDLE;
      end
      SERVICE: if (itr_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= IDLE;
      irq_q_reg     <= '0;
      req_lat_reg   <= '0;
      overrun_reg   <= '0;
      vector_reg    <= 8'h00;
      active_id_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      irq_q_reg   <= irq;
      req_lat_reg <= req_lat_next;
      overrun_reg <= overrun_next;
      // Winner and vector are frozen until the next IDLE->PEND capture.
      if (state_reg == IDLE && any_eligible) begin
        active_id_reg <= winner;
        vector_reg    <= VEC_BASE + {5'd0, winner, 1'b0};
      end
    end
  end

  assign i_pending  = (state_reg == PEND);
  assign in_service = (state_reg == SERVICE);
  assign itr_state  = state_reg;
  assign vector     = vector_reg;
  assign active_id  = active_id_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_mhvpis_ctrl.sv
// Scoreboard bench for mhvpis_ctrl: a behavioural model predicts the outputs after every edge,
// a separate monitor pops and compares them against the DUT.
module tb_mhvpis_ctrl;

  localparam logic [7:0] VEC_BASE = 8'hF0;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] irq = 4'h0;
  logic [3:0] itr_mask = 4'hF;
  logic       itr_ack = 1'b0;
  logic       itr_done = 1'b0;
  logic       i_pending;
  logic [7:0] vector;
  logic [1:0] active_id;
  logic       in_service;
  logic [3:0] overrun;
  logic [2:0] itr_state;

  mhvpis_ctrl #(.VEC_BASE(VEC_BASE), .NSRC(4)) dut (
    .clk(clk), .clr(clr), .irq(irq), .itr_mask(itr_mask), .itr_ack(itr_ack),
    .itr_done(itr_done), .i_pending(i_pending), .vector(vector), .active_id(active_id),
    .in_service(in_service), .overrun(overrun), .itr_state(itr_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pend;
    logic       serv;
    logic [7:0] vec;
    logic [1:0] id;
    logic [3:0] ovr;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // Reference model: phase 0=idle, 1=pending, 2=in service
  int   m_phase = 0;
  bit   m_lat[4];
  bit   m_ovr[4];
  bit   m_prev[4];
  int   m_id = 0;
  int   m_vec = 0;

  task automatic model_step();
    exp_t e;
    bit   new_lat[4];
    int   cleared;
    int   best;
    if (clr) begin
      m_phase = 0; m_id = 0; m_vec = 0;
      for (int i = 0; i < 4; i++) begin m_lat[i] = 0; m_ovr[i] = 0; m_prev[i] = 0; end
    end else begin
      cleared = (m_phase == 1 && itr_ack) ? m_id : -1;
      for (int i = 0; i < 4; i++) begin
        new_lat[i] = m_lat[i];
        if (irq[i] && !m_prev[i]) begin
          if (m_lat[i] && i != cleared) m_ovr[i] = 1;
          new_lat[i] = 1;
        end else if (i == cleared) begin
          new_lat[i] = 0;
        end
      end
      case (m_phase)
        0: begin
          best = -1;
          for (int i = 0; i < 4; i++) if (m_lat[i] && itr_mask[i]) best = i;
          if (best >= 0) begin
            m_phase = 1; m_id = best; m_vec = (int'(VEC_BASE) + 2 * best) % 256;
          end
        end
        1: begin
          if (itr_ack) m_phase = 2;
          else if (!itr_mask[m_id]) m_phase = 0;
        end
        default: if (itr_done) m_phase = 0;
      endcase
      for (int i = 0; i < 4; i++) begin m_lat[i] = new_lat[i]; m_prev[i] = irq[i]; end
    end
    e.pend = (m_phase == 1);
    e.serv = (m_phase == 2);
    e.vec  = 8'(m_vec);
    e.id   = 2'(m_id);
    for (int i = 0; i < 4; i++) e.ovr[i] = m_ovr[i];
    e.st   = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    exp_q.push_back(e);
  endtask

  // One clock: drive on the falling edge, predict at the rising edge.
  task automatic cyc(input logic [3:0] i, input logic [3:0] m, input logic a,
                     input logic d, input logic c);
    @(negedge clk);
    irq = i; itr_mask = m; itr_ack = a; itr_done = d; clr = c;
    @(posedge clk);
    cycle++;
    model_step();
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("i_pending",  int'(i_pending),  int'(e.pend));
        check("in_service", int'(in_service), int'(e.serv));
        check("vector",     int'(vector),     int'(e.vec));
        check("active_id",  int'(active_id),  int'(e.id));
        check("overrun",    int'(overrun),    int'(e.ovr));
        check("itr_state",  int'(itr_state),  int'(e.st));
        $display("[TB] cyc %0d irq=%b mask=%b ack=%b done=%b clr=%b -> st=%b pend=%b srv=%b vec=%02h id=%0d ovr=%b",
                 cycle, irq, itr_mask, itr_ack, itr_done, clr, itr_state, i_pending,
                 in_service, vector, active_id, overrun);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] r_irq;
    logic [3:0] r_mask;
    int wait_cnt;
    repeat (3) cyc(4'h0, 4'hF, 0, 0, 1);
    // Single source 1: latch, pend, ack, done
    cyc(4'h2, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0);
    cyc(4'h0, 4'hF, 0, 0, 0);
    // Sources 0 and 3 together: 3 first, then 0 after one idle cycle
    cyc(4'h9, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 1, 0, 0);
    cyc(4'h0, 4'hF, 0, 1, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    // Masked source 1, then unmasked
    cyc(4'h2, 4'hD, 0, 0, 0); cyc(4'h0, 4'hD, 0, 0, 0); cyc(4'h0, 4'hD, 0, 0, 0);
    cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0);
    // Source 2 pulsed twice before ack: overrun sticks
    cyc(4'h4, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h4, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 0, 0, 0);
    // Mask drop while pending on source 2, then re-enable
    cyc(4'h4, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hB, 0, 0, 0);
    cyc(4'h0, 4'hB, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    // Ack beats a same-cycle mask drop; ack-clear with a fresh edge keeps the request
    cyc(4'h0, 4'hB, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h4, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0);
    cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0);
    // Reset in service with source 3 latched; irq held high through reset release
    cyc(4'h8, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 1, 0, 0);
    cyc(4'h8, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 1); cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 0, 0, 0); cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h2, 4'hF, 0, 0, 1); cyc(4'h2, 4'hF, 0, 0, 0); cyc(4'h2, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 1, 0, 0); cyc(4'h0, 4'hF, 0, 1, 0);
    // Randomized traffic
    r_irq = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      r_irq  = r_irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      r_mask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      cyc(r_irq, r_mask, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) == 0);
    end
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
